// File: rtl/alu_decode_exec.sv
// Single-issue execute slice: writable 4-entry instruction store, identity decoder and 8-bit ALU.
// Optional macro ALU_FLAGS_EN adds registered zero/carry/negative flags.
module alu_decode_exec #(
  parameter int DATA_W  = 8,
  parameter int PC_W    = 2,
  parameter int INSTR_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PC_W-1:0]    pc,
  input  logic [DATA_W-1:0]  a,
  input  logic [DATA_W-1:0]  b,
  input  logic               imem_we,
  input  logic [PC_W-1:0]    imem_waddr,
  input  logic [INSTR_W-1:0] imem_wdata,
  output logic [INSTR_W-1:0] instruction,
  output logic [INSTR_W-1:0] op,
  output logic [DATA_W-1:0]  result,
  output logic [DATA_W-1:0]  result_q
`ifdef ALU_FLAGS_EN
  ,
  output logic               flag_z,
  output logic               flag_c,
  output logic               flag_n
`endif
);

  localparam int DEPTH = 2 ** PC_W;

  localparam logic [INSTR_W-1:0] OP_ADD = INSTR_W'(0);
  localparam logic [INSTR_W-1:0] OP_SUB = INSTR_W'(1);
  localparam logic [INSTR_W-1:0] OP_AND = INSTR_W'(2);
  localparam logic [INSTR_W-1:0] OP_OR  = INSTR_W'(3);
  localparam logic [INSTR_W-1:0] OP_XOR = INSTR_W'(4);
  localparam logic [INSTR_W-1:0] OP_SLL = INSTR_W'(5);
  localparam logic [INSTR_W-1:0] OP_SRL = INSTR_W'(6);
  localparam logic [INSTR_W-1:0] OP_SLT = INSTR_W'(7);

  logic [INSTR_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0]  result_d;
  logic [DATA_W-1:0]  result_reg_q;
  logic               a_lt_b;

  // Reset reloads the default program: each slot holds its own address.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= INSTR_W'(i);
      end
    end else if (imem_we) begin
      mem_q[imem_waddr] <= imem_wdata;
    end
  end

  assign instruction = mem_q[pc];
  assign op          = instruction;
  assign a_lt_b      = (a < b);

  always_comb begin
    result_d = '0;
    case (op)
      OP_ADD:  result_d = a + b;
      OP_SUB:  result_d = a - b;
      OP_AND:  result_d = a & b;
      OP_OR:   result_d = a | b;
      OP_XOR:  result_d = a ^ b;
      OP_SLL:  result_d = a << b[2:0];
      OP_SRL:  result_d = a >> b[2:0];
      OP_SLT:  result_d = {{(DATA_W-1){1'b0}}, a_lt_b};
      default: result_d = '0;
    endcase
  end

  assign result = result_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      result_reg_q <= '0;
    end else begin
      result_reg_q <= result_d;
    end
  end

  assign result_q = result_reg_q;

`ifdef ALU_FLAGS_EN
  logic [DATA_W:0] add_full;
  logic            carry_d;
  logic            flag_z_q;
  logic            flag_c_q;
  logic            flag_n_q;

  assign add_full = {1'b0, a} + {1'b0, b};

  // Carry for ADD is the adder overflow bit; for SUB it is the borrow.
  always_comb begin
    carry_d = 1'b0;
    if (op == OP_ADD) begin
      carry_d = add_full[DATA_W];
    end else if (op == OP_SUB) begin
      carry_d = a_lt_b;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flag_z_q <= 1'b0;
      flag_c_q <= 1'b0;
      flag_n_q <= 1'b0;
    end else begin
      flag_z_q <= (result_d == '0);
      flag_c_q <= carry_d;
      flag_n_q <= result_d[DATA_W-1];
    end
  end

  assign flag_z = flag_z_q;
  assign flag_c = flag_c_q;
  assign flag_n = flag_n_q;
`endif

endmodule

// File: tb/tb_alu_decode_exec.sv
// Self-checking bench for alu_decode_exec: directed plan steps, then random steps against an arithmetic model.
module tb_alu_decode_exec;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] pc;
  logic [7:0] a;
  logic [7:0] b;
  logic       imem_we;
  logic [1:0] imem_waddr;
  logic [2:0] imem_wdata;
  logic [2:0] instruction;
  logic [2:0] op;
  logic [7:0] result;
  logic [7:0] result_q;
`ifdef ALU_FLAGS_EN
  logic       flag_z;
  logic       flag_c;
  logic       flag_n;
`endif

  int checks   = 0;
  int failures = 0;

  // Reference state
  int m_mem [4];
  int m_rq;
  int m_fz, m_fc, m_fn;

  always #5 clk = ~clk;

  alu_decode_exec dut (
    .clk        (clk),
    .rst        (rst),
    .pc         (pc),
    .a          (a),
    .b          (b),
    .imem_we    (imem_we),
    .imem_waddr (imem_waddr),
    .imem_wdata (imem_wdata),
    .instruction(instruction),
    .op         (op),
    .result     (result),
    .result_q   (result_q)
`ifdef ALU_FLAGS_EN
    ,
    .flag_z     (flag_z),
    .flag_c     (flag_c),
    .flag_n     (flag_n)
`endif
  );

  function automatic int alu_model(int opc, int x, int y);
    case (opc)
      0: return (x + y) % 256;
      1: return (x - y + 256) % 256;
      2: return x & y;
      3: return x | y;
      4: return x ^ y;
      5: return (x * (2 ** (y % 8))) % 256;
      6: return x / (2 ** (y % 8));
      default: return (x < y) ? 1 : 0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_mem[i] = i;
    m_rq = 0;
    m_fz = 0;
    m_fc = 0;
    m_fn = 0;
  endtask

  // One clock transaction: drive, check combinational path before the edge,
  // advance the model at the edge, check registered outputs after it.
  // exp_instr / exp_res >= 0 add a literal check from the test plan.
  task automatic step(input string tag, input bit r, input int p, input int x, input int y,
                      input bit we, input int wa, input int wd,
                      input int exp_instr, input int exp_res);
    int ins, res;
    rst = r; pc = p[1:0]; a = x[7:0]; b = y[7:0];
    imem_we = we; imem_waddr = wa[1:0]; imem_wdata = wd[2:0];
    @(negedge clk);
    ins = m_mem[p];
    res = alu_model(ins, x, y);
    chk({tag, ".instruction"}, 32'(instruction), 32'(ins));
    chk({tag, ".op"}, 32'(op), 32'(ins));
    chk({tag, ".result"}, 32'(result), 32'(res));
    if (exp_instr >= 0) chk({tag, ".instr_lit"}, 32'(instruction), 32'(exp_instr));
    if (exp_res >= 0)   chk({tag, ".result_lit"}, 32'(result), 32'(exp_res));
    @(posedge clk);
    if (r) begin
      model_reset();
    end else begin
      if (we) m_mem[wa] = wd;
      m_rq = res;
      m_fz = (res == 0) ? 1 : 0;
      m_fc = (ins == 0) ? (((x + y) > 255) ? 1 : 0) : (ins == 1) ? ((x < y) ? 1 : 0) : 0;
      m_fn = (res >= 128) ? 1 : 0;
    end
    #1;
    chk({tag, ".result_q"}, 32'(result_q), 32'(m_rq));
`ifdef ALU_FLAGS_EN
    chk({tag, ".flag_z"}, 32'(flag_z), 32'(m_fz));
    chk({tag, ".flag_c"}, 32'(flag_c), 32'(m_fc));
    chk({tag, ".flag_n"}, 32'(flag_n), 32'(m_fn));
`endif
    $display("step %s rst=%0d pc=%0d a=%0d b=%0d we=%0d wa=%0d wd=%0d instr=%0d result=%0d result_q=%0d",
             tag, r, p, x, y, we, wa, wd, ins, res, result_q);
  endtask

  initial begin
    rst = 1'b1; pc = '0; a = '0; b = '0;
    imem_we = 1'b0; imem_waddr = '0; imem_wdata = '0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("reset.result_q", 32'(result_q), 32'd0);
`ifdef ALU_FLAGS_EN
    chk("reset.flags", 32'({flag_z, flag_c, flag_n}), 32'd0);
`endif

    // PC sweep over the default program
    step("sweep0", 0, 0, 5, 3, 0, 0, 0, 0, 8);
    step("sweep1", 0, 1, 5, 3, 0, 0, 0, 1, 2);
    step("sweep2", 0, 2, 5, 3, 0, 0, 0, 2, 1);
    step("sweep3", 0, 3, 5, 3, 0, 0, 0, 3, 7);

    step("sub_wrap", 0, 1, 3, 5, 0, 0, 0, 1, 254);
    step("add_ovf", 0, 0, 200, 100, 0, 0, 0, 0, 44);

    // Write SLL into slot 2: old value this cycle, new value after the edge
    step("wr_same", 0, 2, 1, 3, 1, 2, 5, 2, 1);
    step("wr_after", 0, 2, 1, 3, 0, 0, 0, 5, 8);

    // Reset wins over a simultaneous write
    step("rst_prio", 1, 2, 1, 3, 1, 2, 7, 5, 8);
    step("rst_restore", 0, 2, 1, 3, 0, 0, 0, 2, 1);

    step("wr_xor", 0, 0, 0, 0, 1, 3, 4, -1, -1);
    step("xor", 0, 3, 8'hF0, 8'hFF, 0, 0, 0, 4, 8'h0F);
    step("wr_srl", 0, 0, 0, 0, 1, 0, 6, -1, -1);
    step("srl", 0, 0, 8'h80, 7, 0, 0, 0, 6, 1);
    step("wr_slt", 0, 0, 0, 0, 1, 1, 7, -1, -1);
    step("slt_t", 0, 1, 2, 9, 0, 0, 0, 7, 1);
    step("slt_f", 0, 1, 9, 2, 0, 0, 0, 7, 0);

    for (int i = 0; i < 60; i++) begin
      step("rand", ($urandom_range(0, 15) == 0), $urandom_range(0, 3),
           $urandom_range(0, 255), $urandom_range(0, 255),
           $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 7), -1, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
